uart_rx_framer: RTL and testbench

- UART receive front end: oversamples the serial line, recovers start/data/parity/stop framing, and emits one parallel word per good frame.
- Sits directly upstream of the receive shifting row. Its shifting_data / shifting_enable outputs drive that stage's inputs of the same name.
- Each shifting_enable pulse pushes exactly one received word into the row.

---
 rtl/uart_rx_framer_if.sv | 25 ++
 rtl/uart_rx_framer.sv | 204 ++++++++++++++++++++
 tb/tb_uart_rx_framer.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_framer_if.sv
// rtl/uart_rx_framer_if.sv - word/strobe bundle from the UART framer into the receive shifting row
// master = framer side, slave = shifting row side.

interface uart_rx_framer_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  shifting_enable;
  logic [DATA_WIDTH-1:0] shifting_data;
  logic                  frame_error;
  logic                  parity_error;

  modport master (
    output shifting_enable,
    output shifting_data,
    output frame_error,
    output parity_error
  );

  modport slave (
    input shifting_enable,
    input shifting_data,
    input frame_error,
    input parity_error
  );
endinterface

// File: rtl/uart_rx_framer.sv
// rtl/uart_rx_framer.sv - oversampling UART receive framer feeding the receive shifting row
// Recovers start/data/parity/stop framing and emits one word pulse per good frame.

module uart_rx_framer #(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 arst_n,
  input  logic                 rx,
  input  logic [DIV_WIDTH-1:0] baud_div,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  uart_rx_framer_if.master     rx_if
);

  localparam int OS_W  = $clog2(OVERSAMPLE);
  localparam int BIT_W = $clog2(DATA_WIDTH + 1);

  localparam logic [OS_W-1:0]  HALF_M1  = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0]  FULL_M1  = OS_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  state_t state, state_next;

  logic                  rx_m, rx_s;
  logic [DIV_WIDTH-1:0]  div_q, tick_cnt;
  logic                  tick;
  logic [OS_W-1:0]       samp_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic                  par_en_q, par_odd_q, par_bad;
  logic [DATA_WIDTH-1:0] shift_reg;

  logic half_hit, full_hit;
  logic start_go, bit_wrap, data_shift, par_sample;
  logic pulse_ok, pulse_perr, pulse_ferr;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  // Configuration is frozen at the start edge; mid-frame changes wait for the next frame.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      div_q     <= DIV_WIDTH'(1);
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
    end else if (start_go) begin
      div_q     <= (baud_div == '0) ? DIV_WIDTH'(1) : baud_div;
      par_en_q  <= parity_en;
      par_odd_q <= parity_odd;
    end
  end

  assign tick = (tick_cnt >= div_q - DIV_WIDTH'(1));

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      tick_cnt <= '0;
    end else if (start_go || tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + DIV_WIDTH'(1);
    end
  end

  assign half_hit = tick && (samp_cnt == HALF_M1);
  assign full_hit = tick && (samp_cnt == FULL_M1);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // IDLE is only ever entered with rx_s high, so a low level there is a falling edge.
  always_comb begin
    state_next = state;
    start_go   = 1'b0;
    bit_wrap   = 1'b0;
    data_shift = 1'b0;
    par_sample = 1'b0;
    pulse_ok   = 1'b0;
    pulse_perr = 1'b0;
    pulse_ferr = 1'b0;
    case (state)
      S_IDLE: begin
        if (!rx_s) begin
          start_go   = 1'b1;
          state_next = S_START;
        end
      end
      S_START: begin
        if (half_hit) begin
          bit_wrap   = 1'b1;
          state_next = rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (full_hit) begin
          bit_wrap   = 1'b1;
          data_shift = 1'b1;
          if (bit_cnt == BIT_LAST) begin
            state_next = par_en_q ? S_PARITY : S_STOP;
          end
        end
      end
      S_PARITY: begin
        if (full_hit) begin
          bit_wrap   = 1'b1;
          par_sample = 1'b1;
          state_next = S_STOP;
        end
      end
      S_STOP: begin
        if (full_hit) begin
          bit_wrap = 1'b1;
          if (rx_s) begin
            state_next = S_IDLE;
            if (par_bad) begin
              pulse_perr = 1'b1;
            end else begin
              pulse_ok = 1'b1;
            end
          end else begin
            pulse_ferr = 1'b1;
            state_next = S_WAIT_IDLE;
          end
        end
      end
      S_WAIT_IDLE: begin
        if (rx_s) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      samp_cnt <= '0;
    end else if (start_go || bit_wrap) begin
      samp_cnt <= '0;
    end else if (tick && (state != S_IDLE) && (state != S_WAIT_IDLE)) begin
      samp_cnt <= samp_cnt + 1'b1;
    end
  end

  // LSB arrives first, so shifting in from the top leaves bit k at index k.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      bit_cnt   <= '0;
      shift_reg <= '0;
      par_bad   <= 1'b0;
    end else if (start_go) begin
      bit_cnt <= '0;
      par_bad <= 1'b0;
    end else begin
      if (data_shift) begin
        bit_cnt   <= bit_cnt + 1'b1;
        shift_reg <= {rx_s, shift_reg[DATA_WIDTH-1:1]};
      end
      if (par_sample) begin
        par_bad <= rx_s ^ (^shift_reg) ^ par_odd_q;
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      rx_if.shifting_enable <= 1'b0;
      rx_if.shifting_data   <= '0;
      rx_if.frame_error     <= 1'b0;
      rx_if.parity_error    <= 1'b0;
    end else begin
      rx_if.shifting_enable <= pulse_ok;
      rx_if.frame_error     <= pulse_ferr;
      rx_if.parity_error    <= pulse_perr;
      if (pulse_ok) begin
        rx_if.shifting_data <= shift_reg;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_framer.sv
// tb/tb_uart_rx_framer.sv - directed self-checking bench for uart_rx_framer

module tb_uart_rx_framer;

  localparam int DW   = 8;
  localparam int OS   = 16;
  localparam int DIVW = 16;
  localparam int LAT  = OS * (DW + 1) + OS / 2 + 3;

  logic            clk = 1'b0;
  logic            arst_n;
  logic            rx;
  logic [DIVW-1:0] baud_div;
  logic            parity_en;
  logic            parity_odd;

  uart_rx_framer_if #(.DATA_WIDTH(DW)) rif ();

  uart_rx_framer #(
    .DATA_WIDTH(DW),
    .OVERSAMPLE(OS),
    .DIV_WIDTH (DIVW)
  ) dut (
    .clk       (clk),
    .arst_n    (arst_n),
    .rx        (rx),
    .baud_div  (baud_div),
    .parity_en (parity_en),
    .parity_odd(parity_odd),
    .rx_if     (rif)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0, n_miss = 0;
  int en_cnt = 0, fe_cnt = 0, pe_cnt = 0, multi = 0, dbl = 0;
  int en_cyc = 0, start_cyc = 0;
  logic en_prev = 1'b0;
  logic [DW-1:0] rx_log [0:31];

  always @(negedge clk) begin
    if (arst_n === 1'b1) begin
      if (rif.shifting_enable === 1'b1) begin
        rx_log[en_cnt % 32] = rif.shifting_data;
        en_cnt++;
        en_cyc = cyc;
      end
      if (rif.frame_error === 1'b1) fe_cnt++;
      if (rif.parity_error === 1'b1) pe_cnt++;
      if (int'(rif.shifting_enable) + int'(rif.frame_error) + int'(rif.parity_error) > 1) multi++;
      if ((rif.shifting_enable === 1'b1) && en_prev) dbl++;
      en_prev = (rif.shifting_enable === 1'b1);
    end else begin
      en_prev = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic b, input int n);
    rx = b;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input int per, input bit has_par,
                            input logic pbit, input logic stop_b);
    start_cyc = cyc;
    drive_bit(1'b0, per);
    for (int i = 0; i < DW; i++) drive_bit(d[i], per);
    if (has_par) drive_bit(pbit, per);
    drive_bit(stop_b, per);
  endtask

  initial begin
    arst_n     = 1'b0;
    rx         = 1'b1;
    baud_div   = 16'd1;
    parity_en  = 1'b0;
    parity_odd = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_data", 32'(rif.shifting_data), 32'h00);
    chk("rst_en",   32'(rif.shifting_enable), 32'h0);
    chk("rst_fe",   32'(rif.frame_error), 32'h0);
    chk("rst_pe",   32'(rif.parity_error), 32'h0);

    @(posedge clk); #1;
    arst_n = 1'b1;
    drive_bit(1'b1, 1000);
    chk("idle_en",   en_cnt, 0);
    chk("idle_fe",   fe_cnt, 0);
    chk("idle_pe",   pe_cnt, 0);
    chk("idle_data", 32'(rif.shifting_data), 32'h00);

    send_frame(8'hA5, OS, 1'b0, 1'b0, 1'b1);
    drive_bit(1'b1, 32);
    chk("a5_cnt",  en_cnt, 1);
    chk("a5_data", 32'(rif.shifting_data), 32'hA5);
    chk("a5_lat",  en_cyc - start_cyc, LAT);

    // back-to-back, baud_div 3, even parity (0x3C, 0xFF, 0x00 all have even weight)
    baud_div  = 16'd3;
    parity_en = 1'b1;
    parity_odd = 1'b0;
    send_frame(8'h3C, OS * 3, 1'b1, 1'b0, 1'b1);
    send_frame(8'hFF, OS * 3, 1'b1, 1'b0, 1'b1);
    send_frame(8'h00, OS * 3, 1'b1, 1'b0, 1'b1);
    drive_bit(1'b1, 96);
    chk("b2b_cnt", en_cnt, 4);
    chk("b2b_d0",  32'(rx_log[1]), 32'h3C);
    chk("b2b_d1",  32'(rx_log[2]), 32'hFF);
    chk("b2b_d2",  32'(rx_log[3]), 32'h00);
    chk("b2b_pe",  pe_cnt, 0);
    chk("b2b_fe",  fe_cnt, 0);

    parity_odd = 1'b1;
    send_frame(8'h01, OS * 3, 1'b1, 1'b0, 1'b1);
    drive_bit(1'b1, 48);
    chk("odd_ok_cnt",  en_cnt, 5);
    chk("odd_ok_data", 32'(rif.shifting_data), 32'h01);

    parity_odd = 1'b0;
    send_frame(8'h02, OS * 3, 1'b1, 1'b1, 1'b1);
    drive_bit(1'b1, 48);
    chk("even_ok_cnt",  en_cnt, 6);
    chk("even_ok_data", 32'(rif.shifting_data), 32'h02);

    parity_odd = 1'b1;
    send_frame(8'h81, OS * 3, 1'b1, 1'b0, 1'b1);
    drive_bit(1'b1, 48);
    chk("perr_pe",   pe_cnt, 1);
    chk("perr_en",   en_cnt, 6);
    chk("perr_data", 32'(rif.shifting_data), 32'h02);

    // stop bit low, then a 5-bit-time break
    baud_div  = 16'd1;
    parity_en = 1'b0;
    send_frame(8'h55, OS, 1'b0, 1'b0, 1'b0);
    drive_bit(1'b0, 5 * OS);
    drive_bit(1'b1, 32);
    chk("brk_fe", fe_cnt, 1);
    chk("brk_en", en_cnt, 6);
    chk("brk_pe", pe_cnt, 1);

    send_frame(8'h5A, OS, 1'b0, 1'b0, 1'b1);
    drive_bit(1'b1, 32);
    chk("post_brk_cnt",  en_cnt, 7);
    chk("post_brk_data", 32'(rif.shifting_data), 32'h5A);

    // bad parity and bad stop together: frame error only
    parity_en  = 1'b1;
    parity_odd = 1'b0;
    send_frame(8'h96, OS, 1'b1, 1'b1, 1'b0);
    drive_bit(1'b0, 32);
    drive_bit(1'b1, 32);
    chk("both_fe", fe_cnt, 2);
    chk("both_pe", pe_cnt, 1);
    chk("both_en", en_cnt, 7);

    parity_en = 1'b0;
    drive_bit(1'b0, OS / 4);
    drive_bit(1'b1, 100);
    chk("glitch_en", en_cnt, 7);
    chk("glitch_fe", fe_cnt, 2);
    chk("glitch_pe", pe_cnt, 1);

    send_frame(8'hE7, OS, 1'b0, 1'b0, 1'b1);
    drive_bit(1'b1, 32);
    chk("post_glitch_cnt",  en_cnt, 8);
    chk("post_glitch_data", 32'(rif.shifting_data), 32'hE7);

    // reset asserted while the framer is in DATA, held until the line is idle again
    fork
      send_frame(8'h33, OS, 1'b0, 1'b0, 1'b1);
      begin
        repeat (60) @(posedge clk);
        #1;
        arst_n = 1'b0;
      end
    join
    @(negedge clk);
    chk("mid_rst_data", 32'(rif.shifting_data), 32'h00);
    chk("mid_rst_en",   32'(rif.shifting_enable), 32'h0);
    @(posedge clk); #1;
    arst_n = 1'b1;
    drive_bit(1'b1, 40);
    chk("mid_rst_cnt", en_cnt, 8);
    chk("mid_rst_fe",  fe_cnt, 2);

    baud_div = 16'd0;
    send_frame(8'h77, OS, 1'b0, 1'b0, 1'b1);
    drive_bit(1'b1, 32);
    chk("d77_cnt",  en_cnt, 9);
    chk("d77_data", 32'(rif.shifting_data), 32'h77);
    chk("d77_lat",  en_cyc - start_cyc, LAT);

    chk("onehot", multi, 0);
    chk("no_dbl", dbl, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
